ber_checker_mc: RTL and testbench

BER_CHECKER_MC -- requirements
Module: ber_checker_mc

---
 rtl/ber_pkg.sv | 29 ++
 rtl/ber_chan.sv | 159 +++++++++++++++
 rtl/ber_checker_mc.sv | 58 +++++
 tb/tb_ber_checker_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared definitions for the multi-channel PRBS bit-error-rate checker:
// channel FSM state encoding and PRBS polynomial tap selection.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_t;

  // Second feedback tap (1-based) of x^N + x^M + 1; the first tap is always N.
  function automatic int prbs_tap(input int order);
    int tap;
    case (order)
      7:       tap = 6;
      9:       tap = 5;
      15:      tap = 14;
      23:      tap = 18;
      31:      tap = 28;
      default: tap = 5;
    endcase
    return tap;
  endfunction

  function automatic bit prbs_legal(input int order);
    return (order == 7) || (order == 9) || (order == 15) || (order == 23) || (order == 31);
  endfunction

endpackage

// File: rtl/ber_chan.sv
// One receive channel: HUNT/SYNC/LOCKED FSM, self-synchronising PRBS checker and counters.
// Define BER_AUTO_RESYNC_EN to add windowed loss-of-lock detection.
module ber_chan
  import ber_pkg::*;
#(
  parameter int PRBS_ORDER = 9,
  parameter int SYNC_LEN   = 64,
  parameter int CNT_W      = 48,
  parameter int ERR_OK_MAX = 0,
  parameter int WIN_LEN    = 1024,
  parameter int LOSS_THR   = 64
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_rx_bit,
  input  logic             i_clear,
  input  logic             i_resync,
  output logic             o_lock,
  output logic             o_ber_ok,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_tot_cnt,
  output ber_state_t       o_state
);

  localparam int TAP_A  = PRBS_ORDER - 1;
  localparam int TAP_B  = prbs_tap(PRBS_ORDER) - 1;
  localparam int MC_MAX = (SYNC_LEN > PRBS_ORDER) ? SYNC_LEN : PRBS_ORDER;
  localparam int MCW    = $clog2(MC_MAX + 1);

  if (!prbs_legal(PRBS_ORDER) || SYNC_LEN < 1 || CNT_W < 1 || WIN_LEN < 1 || LOSS_THR < 1)
  begin : g_bad_cfg
    $error("ber_chan: illegal parameter set");
  end

  ber_state_t            state_q;
  ber_state_t            state_d;
  logic [PRBS_ORDER-1:0] sr_q;
  logic [MCW-1:0]        mcnt_q;
  logic [CNT_W-1:0]      err_q;
  logic [CNT_W-1:0]      tot_q;
  logic                  exp_bit;
  logic                  mismatch;
  logic                  step;
  logic                  hunt_done;
  logic                  sync_done;
  logic                  loss_hit;
  logic                  tot_full;

  assign exp_bit   = sr_q[TAP_A] ^ sr_q[TAP_B];
  assign mismatch  = i_rx_bit ^ exp_bit;
  assign step      = i_en & ~i_resync;
  assign hunt_done = (mcnt_q == MCW'(PRBS_ORDER - 1));
  assign sync_done = (mcnt_q == MCW'(SYNC_LEN - 1));
  assign tot_full  = &tot_q;

`ifdef BER_AUTO_RESYNC_EN
  localparam int WCW = $clog2(WIN_LEN + 1);
  localparam int WEW = $clog2(LOSS_THR + 1);

  logic [WCW-1:0] win_q;
  logic [WEW-1:0] werr_q;

  // The error that brings the window count to LOSS_THR drops lock on that same strobe.
  assign loss_hit = (state_q == ST_LOCKED) && mismatch && (werr_q == WEW'(LOSS_THR - 1));

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      win_q  <= '0;
      werr_q <= '0;
    end else if (step) begin
      if (state_q != ST_LOCKED || loss_hit || win_q == WCW'(WIN_LEN - 1)) begin
        win_q  <= '0;
        werr_q <= '0;
      end else begin
        win_q  <= win_q + WCW'(1);
        werr_q <= werr_q + WEW'(mismatch);
      end
    end
  end
`else
  assign loss_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_resync) begin
      state_d = ST_HUNT;
    end else if (i_en) begin
      case (state_q)
        ST_HUNT:   if (hunt_done) state_d = ST_SYNC;
        ST_SYNC: begin
          if (mismatch)       state_d = ST_HUNT;
          else if (sync_done) state_d = ST_LOCKED;
        end
        ST_LOCKED: if (loss_hit) state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    o_lock   = (state_q == ST_LOCKED);
    o_ber_ok = o_lock && (err_q <= CNT_W'(ERR_OK_MAX));
    o_state  = state_q;
  end

  // Once locked the register regenerates the sequence itself, so received errors never enter it.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sr_q   <= '0;
      mcnt_q <= '0;
    end else if (i_resync) begin
      mcnt_q <= '0;
    end else if (i_en) begin
      case (state_q)
        ST_HUNT: begin
          sr_q   <= {sr_q[PRBS_ORDER-2:0], i_rx_bit};
          mcnt_q <= hunt_done ? '0 : mcnt_q + MCW'(1);
        end
        ST_SYNC: begin
          sr_q   <= {sr_q[PRBS_ORDER-2:0], i_rx_bit};
          mcnt_q <= (mismatch || sync_done) ? '0 : mcnt_q + MCW'(1);
        end
        ST_LOCKED: begin
          sr_q   <= {sr_q[PRBS_ORDER-2:0], exp_bit};
          mcnt_q <= '0;
        end
        default: mcnt_q <= '0;
      endcase
    end
  end

  // Clear wins over a coincident counting strobe; a full total freezes both counters.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      err_q <= '0;
      tot_q <= '0;
    end else if (i_clear) begin
      err_q <= '0;
      tot_q <= '0;
    end else if (step && state_q == ST_LOCKED && !tot_full) begin
      tot_q <= tot_q + CNT_W'(1);
      err_q <= err_q + CNT_W'(mismatch);
    end
  end

  assign o_err_cnt = err_q;
  assign o_tot_cnt = tot_q;

endmodule

// File: rtl/ber_checker_mc.sv
// Multi-channel PRBS BER checker: N_CH independent ber_chan instances with packed outputs.
// Define BER_AUTO_RESYNC_EN to enable windowed loss-of-lock in every channel.
module ber_checker_mc
  import ber_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int PRBS_ORDER = 9,
  parameter int SYNC_LEN   = 64,
  parameter int CNT_W      = 48,
  parameter int ERR_OK_MAX = 0,
  parameter int WIN_LEN    = 1024,
  parameter int LOSS_THR   = 64
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [N_CH-1:0]       i_rx_bit,
  input  logic                  i_clear,
  input  logic                  i_resync,
  output logic [N_CH-1:0]       o_lock,
  output logic [N_CH-1:0]       o_ber_ok,
  output logic [N_CH*CNT_W-1:0] o_err_cnt,
  output logic [N_CH*CNT_W-1:0] o_tot_cnt,
  output logic [2*N_CH-1:0]     o_dbg_state
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("ber_checker_mc: N_CH must be 1..8");
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    ber_state_t chan_state;

    ber_chan #(
      .PRBS_ORDER (PRBS_ORDER),
      .SYNC_LEN   (SYNC_LEN),
      .CNT_W      (CNT_W),
      .ERR_OK_MAX (ERR_OK_MAX),
      .WIN_LEN    (WIN_LEN),
      .LOSS_THR   (LOSS_THR)
    ) u_chan (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_en      (i_en),
      .i_rx_bit  (i_rx_bit[k]),
      .i_clear   (i_clear),
      .i_resync  (i_resync),
      .o_lock    (o_lock[k]),
      .o_ber_ok  (o_ber_ok[k]),
      .o_err_cnt (o_err_cnt[k*CNT_W +: CNT_W]),
      .o_tot_cnt (o_tot_cnt[k*CNT_W +: CNT_W]),
      .o_state   (chan_state)
    );

    assign o_dbg_state[2*k +: 2] = chan_state;
  end

endmodule

// File: tb/tb_ber_checker_mc.sv
// Bench for ber_checker_mc: table of PRBS9 two-channel segments with expected end state,
// plus hand-written PRBS15 / CNT_W=8 sequences for strobe gating and saturation.
module tb_ber_checker_mc;
  import ber_pkg::*;

  localparam int CW = 48;
  localparam int W  = 4 + 4 * CW;

  typedef struct {
    string      name;
    int         n;
    logic       en;
    logic [1:0] flip;
    logic       flip_all;
    logic       clr;
    logic       rs;
    logic [1:0] lock;
    logic [1:0] ok;
    int         err0;
    int         err1;
    int         tot0;
    int         tot1;
  } row_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 2 channels, PRBS9, 48-bit counters
  logic          a_en, a_clear, a_resync;
  logic [1:0]    a_rx, a_lock, a_ok;
  logic [2*CW-1:0] a_err, a_tot;
  logic [3:0]    a_dbg;

  // DUT B: 1 channel, PRBS15, 8-bit counters
  logic          b_en, b_clear, b_resync;
  logic [0:0]    b_rx, b_lock, b_ok;
  logic [7:0]    b_err, b_tot;
  logic [1:0]    b_dbg;

  ber_checker_mc #(.N_CH(2), .PRBS_ORDER(9), .SYNC_LEN(64), .CNT_W(CW), .ERR_OK_MAX(0),
                   .WIN_LEN(1024), .LOSS_THR(64)) dut_a (
    .clk(clk), .i_reset(rst_n), .i_en(a_en), .i_rx_bit(a_rx), .i_clear(a_clear),
    .i_resync(a_resync), .o_lock(a_lock), .o_ber_ok(a_ok), .o_err_cnt(a_err),
    .o_tot_cnt(a_tot), .o_dbg_state(a_dbg)
  );

  ber_checker_mc #(.N_CH(1), .PRBS_ORDER(15), .SYNC_LEN(64), .CNT_W(8), .ERR_OK_MAX(0),
                   .WIN_LEN(1024), .LOSS_THR(64)) dut_b (
    .clk(clk), .i_reset(rst_n), .i_en(b_en), .i_rx_bit(b_rx), .i_clear(b_clear),
    .i_resync(b_resync), .o_lock(b_lock), .o_ber_ok(b_ok), .o_err_cnt(b_err),
    .o_tot_cnt(b_tot), .o_dbg_state(b_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  row_t         rows[$];
  int           n_checks = 0;
  int           n_err    = 0;
  int           reset_at = 0;

  // reference PRBS generators (independent of the DUT)
  logic [8:0]  g9_0, g9_1;
  logic [14:0] g15;

  function automatic logic [W-1:0] pack(input logic [1:0] lock, input logic [1:0] ok,
                                        input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                                        input logic [CW-1:0] t0, input logic [CW-1:0] t1);
    return {lock, ok, e1, e0, t1, t0};
  endfunction

  function automatic logic [W-1:0] act_a();
    return pack(a_lock, a_ok, a_err[CW-1:0], a_err[2*CW-1:CW], a_tot[CW-1:0], a_tot[2*CW-1:CW]);
  endfunction

  function automatic logic [W-1:0] act_b();
    return pack({1'b0, b_lock}, {1'b0, b_ok}, CW'(b_err), '0, CW'(b_tot), '0);
  endfunction

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h, scoreboard has no expected value", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h want %h", name, act, e);
      end
    end
  endtask

  // driver tasks
  task automatic a_cycle(input logic en, input logic [1:0] flip, input logic clr, input logic rs);
    logic b0, b1;
    if (en && !rs) begin
      b0 = g9_0[8] ^ g9_0[4];
      b1 = g9_1[8] ^ g9_1[4];
      g9_0 = {g9_0[7:0], b0};
      g9_1 = {g9_1[7:0], b1};
      a_rx = {b1, b0} ^ flip;
    end else begin
      a_rx = 2'($urandom_range(0, 3));
    end
    a_en = en; a_clear = clr; a_resync = rs;
    @(posedge clk); #1;
    a_en = 1'b0; a_clear = 1'b0; a_resync = 1'b0;
  endtask

  task automatic b_cycle(input logic en, input logic flip, input logic clr);
    logic nb;
    if (en) begin
      nb = g15[14] ^ g15[13];
      g15 = {g15[13:0], nb};
      b_rx[0] = nb ^ flip;
    end else begin
      b_rx = 1'($urandom_range(0, 1));
    end
    b_en = en; b_clear = clr;
    @(posedge clk); #1;
    b_en = 1'b0; b_clear = 1'b0;
  endtask

  task automatic add_row(input string name, input int n, input logic en, input logic [1:0] flip,
                         input logic flip_all, input logic clr, input logic rs,
                         input logic [1:0] lock, input logic [1:0] ok,
                         input int e0, input int e1, input int t0, input int t1);
    row_t r;
    r.name = name; r.n = n; r.en = en; r.flip = flip; r.flip_all = flip_all;
    r.clr = clr; r.rs = rs; r.lock = lock; r.ok = ok;
    r.err0 = e0; r.err1 = e1; r.tot0 = t0; r.tot1 = t1;
    rows.push_back(r);
  endtask

  task automatic run_row(input row_t r);
    expect_val(pack(r.lock, r.ok, CW'(r.err0), CW'(r.err1), CW'(r.tot0), CW'(r.tot1)));
    for (int c = 0; c < r.n; c++)
      a_cycle(r.en, (r.flip_all || c == r.n - 1) ? r.flip : 2'b00, r.clr, r.rs);
    check(r.name, act_a());
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    expect_val('0);
    check("async_reset_no_edge", act_a());
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dbg_exp;
    rst_n = 1'b0;
    a_en = 1'b0; a_clear = 1'b0; a_resync = 1'b0; a_rx = 2'b00;
    b_en = 1'b0; b_clear = 1'b0; b_resync = 1'b0; b_rx = 1'b0;
    g9_0 = 9'h1A5; g9_1 = 9'h0F3; g15 = 15'h2C71;

    //      name              n    en flip  all clr rs  lock   ok     e0  e1  t0    t1
    add_row("clean_72",       72,  1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0,    0);
    add_row("lock_73",        1,   1, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0,  0,  0,    0);
    add_row("clean_1000",     1000,1, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0,  0,  1000, 1000);
    add_row("flip_ch1",       1,   1, 2'b10, 0, 0, 0, 2'b11, 2'b01, 0,  1,  1001, 1001);
    add_row("clean_50",       50,  1, 2'b00, 0, 0, 0, 2'b11, 2'b01, 0,  1,  1051, 1051);
    add_row("flip_both",      1,   1, 2'b11, 0, 0, 0, 2'b11, 2'b00, 1,  2,  1052, 1052);
    add_row("clear_on_strobe",1,   1, 2'b00, 0, 1, 0, 2'b11, 2'b11, 0,  0,  0,    0);
    add_row("count_10",       10,  1, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0,  0,  10,   10);
    add_row("en_low_hold",    5,   0, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0,  0,  10,   10);
    add_row("resync",         1,   1, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0,  0,  10,   10);
    add_row("hunt_30",        30,  1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0,  0,  10,   10);
    add_row("sync_err_ch0",   1,   1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0,  0,  10,   10);
    add_row("ch1_lock_73",    42,  1, 2'b00, 0, 0, 0, 2'b10, 2'b10, 0,  0,  10,   10);
    add_row("ch0_pre_lock",   30,  1, 2'b00, 0, 0, 0, 2'b10, 2'b10, 0,  0,  10,   40);
    add_row("ch0_lock_104",   1,   1, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0,  0,  10,   41);
    reset_at = rows.size();
    add_row("post_rst_72",    72,  1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0,    0);
    add_row("post_rst_73",    1,   1, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0,  0,  0,    0);
    add_row("inv_ch0_63",     63,  1, 2'b01, 1, 0, 0, 2'b11, 2'b10, 63, 0,  63,   63);
`ifdef BER_AUTO_RESYNC_EN
    add_row("inv_ch0_64",     1,   1, 2'b01, 0, 0, 0, 2'b10, 2'b10, 64, 0,  64,   64);
    add_row("relock_72",      72,  1, 2'b00, 0, 0, 0, 2'b10, 2'b10, 64, 0,  64,   136);
    add_row("relock_73",      1,   1, 2'b00, 0, 0, 0, 2'b11, 2'b10, 64, 0,  64,   137);
`else
    add_row("inv_ch0_64",     1,   1, 2'b01, 0, 0, 0, 2'b11, 2'b10, 64, 0,  64,   64);
    add_row("locked_72",      72,  1, 2'b00, 0, 0, 0, 2'b11, 2'b10, 64, 0,  136,  136);
    add_row("locked_73",      1,   1, 2'b00, 0, 0, 0, 2'b11, 2'b10, 64, 0,  137,  137);
`endif

    repeat (3) @(posedge clk);
    #1;
    expect_val('0);
    check("reset_outputs_a", act_a());
    expect_val('0);
    check("reset_outputs_b", act_b());
    dbg_exp = {ST_HUNT, ST_HUNT};
    expect_val(W'(dbg_exp));
    check("reset_dbg_a", W'(a_dbg));
    rst_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      if (i == reset_at) reset_pulse();
      run_row(rows[i]);
      if (i == 0) begin
        dbg_exp = {ST_SYNC, ST_SYNC};
        expect_val(W'(dbg_exp));
        check("dbg_sync_after_72", W'(a_dbg));
      end
    end

    // PRBS15 with a 1-in-4 strobe: lock counts strobes, not cycles
    for (int s = 0; s < 78; s++) begin
      b_cycle(1'b1, 1'b0, 1'b0);
      repeat (3) b_cycle(1'b0, 1'b0, 1'b0);
    end
    expect_val('0);
    check("b_sparse_78_strobes", act_b());
    b_cycle(1'b1, 1'b0, 1'b0);
    repeat (3) b_cycle(1'b0, 1'b0, 1'b0);
    expect_val(pack(2'b01, 2'b01, '0, '0, '0, '0));
    check("b_sparse_lock_79", act_b());
    expect_val(W'({ST_LOCKED}));
    check("b_dbg_locked", W'(b_dbg));
    for (int s = 0; s < 4; s++) begin
      b_cycle(1'b1, 1'b0, 1'b0);
      repeat (3) b_cycle(1'b0, 1'b0, 1'b0);
    end
    expect_val(pack(2'b01, 2'b01, '0, '0, CW'(4), '0));
    check("b_sparse_count_4", act_b());

    // dense strobes: one error, then saturation at 255
    b_cycle(1'b1, 1'b0, 1'b0);
    b_cycle(1'b1, 1'b0, 1'b0);
    b_cycle(1'b1, 1'b1, 1'b0);
    b_cycle(1'b1, 1'b0, 1'b0);
    b_cycle(1'b1, 1'b0, 1'b0);
    expect_val(pack(2'b01, 2'b00, CW'(1), '0, CW'(9), '0));
    check("b_one_error", act_b());
    repeat (300) b_cycle(1'b1, 1'b0, 1'b0);
    expect_val(pack(2'b01, 2'b00, CW'(1), '0, CW'(255), '0));
    check("b_tot_saturated", act_b());
    b_cycle(1'b1, 1'b1, 1'b0);
    expect_val(pack(2'b01, 2'b00, CW'(1), '0, CW'(255), '0));
    check("b_frozen_after_sat", act_b());
    b_cycle(1'b0, 1'b0, 1'b1);
    expect_val(pack(2'b01, 2'b01, '0, '0, '0, '0));
    check("b_clear", act_b());
    repeat (3) b_cycle(1'b1, 1'b0, 1'b0);
    expect_val(pack(2'b01, 2'b01, '0, '0, CW'(3), '0));
    check("b_count_after_clear", act_b());

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
